// File: rtl/mont_mul_r2_if.sv
// Start/done handshake and operand/result bus for the radix-2 Montgomery multiplier.
interface mont_mul_r2_if;
    logic         start;
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] p;
    logic         busy;
    logic         done;
    logic [255:0] res;

    modport master (output start, output a, output b, output p,
                    input  busy,  input  done, input  res);
    modport slave  (input  start, input  a, input  b, input  p,
                    output busy,  output done, output res);
endinterface

// File: rtl/mont_mul_r2.sv
// Radix-2 interleaved Montgomery multiplier: res = a*b*2^-256 mod p, fully reduced.
// Define MONT_MUL_TWO_ITER_EN to retire two multiplier bits per LOOP cycle.
module mont_mul_r2 (
    input  logic          clk,
    input  logic          rst,
    mont_mul_r2_if.slave  mm
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOOP  = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [255:0] a_q, a_d;
    logic [255:0] b_q, b_d;
    logic [255:0] p_q, p_d;
    logic [257:0] s_q, s_d;
    logic [7:0]   i_q, i_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [255:0] res_q, res_d;
    logic         s_ge_p;

    // One interleaved step; S < 2p keeps t + q*p inside 258 bits before the halving.
    function automatic logic [257:0] mont_step(input logic [257:0] s,
                                               input logic         a_bit,
                                               input logic [255:0] bv,
                                               input logic [255:0] pv);
        logic [257:0] t;
        logic [257:0] u;
        t = s + (a_bit ? {2'b00, bv} : 258'd0);
        u = t + (t[0] ? {2'b00, pv} : 258'd0);
        return {1'b0, u[257:1]};
    endfunction

    assign s_ge_p = (s_q >= {2'b00, p_q});

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        s_d     = s_q;
        i_d     = i_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (mm.start) begin
                    a_d     = mm.a;
                    b_d     = mm.b;
                    p_d     = mm.p;
                    s_d     = 258'd0;
                    i_d     = 8'd0;
                    busy_d  = 1'b1;
                    state_d = LOOP;
                end
            end
            LOOP: begin
`ifdef MONT_MUL_TWO_ITER_EN
                s_d = mont_step(mont_step(s_q, a_q[i_q], b_q, p_q),
                                a_q[i_q + 8'd1], b_q, p_q);
                i_d = i_q + 8'd2;
                if (i_q == 8'd254) begin
                    state_d = FINAL;
                end
`else
                s_d = mont_step(s_q, a_q[i_q], b_q, p_q);
                i_d = i_q + 8'd1;
                if (i_q == 8'd255) begin
                    state_d = FINAL;
                end
`endif
            end
            FINAL: begin
                // S < 2p, so the low 256 bits of S - p are exact whenever S >= p.
                res_d   = s_ge_p ? (s_q[255:0] - p_q) : s_q[255:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            s_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            s_q     <= s_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign mm.busy = busy_q;
    assign mm.done = done_q;
    assign mm.res  = res_q;

endmodule
